riscv_seq_ctrl: RTL and testbench

Multi-cycle instruction sequencer for the RV32 ALU/branch datapath. It fetches a 32-bit instruction word over a req/ack instruction-memory port and decodes R-type (0110011), I-type (0010011) and B-type (1100011) instructions. It then drives register addresses, ALU select/control and immediate into the datapath, and updates the PC from the datapath branch-taken flag. It also performs register-file writeback and counts retired instructions.

---
 rtl/riscv_seq_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_riscv_seq_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_seq_ctrl.sv
// rtl/riscv_seq_ctrl.sv - multi-cycle RV32 ALU/branch instruction sequencer
//
// Purpose: fetches an instruction over a req/ack port, decodes R/I/B types,
// drives datapath controls, resolves branches, writes back and counts retires.
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   start, stop                run control (start in IDLE, stop at instruction end)
//   imem_req/addr/ack/rdata    instruction fetch handshake
//   alu_sel, alu_control       instruction class and funct3
//   rs1/rs2/rd_addr, imm       register addresses and sign-extended immediate
//   alu_en, bt, rf_we          exec strobe, branch-taken input, writeback strobe
//   pc, busy, fault, retired   status
module riscv_seq_ctrl #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int          EXEC_CYCLES   = 2,
    parameter int          FETCH_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [1:0]  alu_sel,
    output logic [2:0]  alu_control,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    output logic [4:0]  rd_addr,
    output logic [31:0] imm,
    output logic        alu_en,
    input  logic        bt,
    output logic        rf_we,
    output logic [31:0] pc,
    output logic        busy,
    output logic [1:0]  fault,
    output logic [31:0] retired
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] OP_B = 7'b1100011;

    localparam logic [7:0] FETCH_LAST = 8'(FETCH_TIMEOUT - 1);
    localparam logic [3:0] EXEC_LAST  = 4'(EXEC_CYCLES - 1);

    logic [2:0]  state;
    logic [31:0] instr;
    logic [7:0]  fetch_cnt;
    logic [3:0]  exec_cnt;

    // Decode of the incoming word so fields are already valid during DECODE
    // and then hold until the next fetch completes.
    logic [1:0]  d_sel;
    logic [4:0]  d_rd;
    logic [31:0] d_imm;
    logic [6:0]  d_op;

    always_comb begin
        d_op  = imem_rdata[6:0];
        d_sel = 2'b00;
        d_rd  = imem_rdata[11:7];
        d_imm = 32'h0;
        if (d_op == OP_I) begin
            d_sel = 2'b01;
            d_imm = {{20{imem_rdata[31]}}, imem_rdata[31:20]};
        end else if (d_op == OP_B) begin
            d_sel = 2'b10;
            d_rd  = 5'd0;
            d_imm = {{20{imem_rdata[31]}}, imem_rdata[7], imem_rdata[30:25],
                     imem_rdata[11:8], 1'b0};
        end
    end

    // Legality check on the latched instruction, used in DECODE.
    logic legal;
    always_comb begin
        case (instr[6:0])
            OP_R:    legal = (instr[14:12] <= 3'b100);
            OP_I:    legal = (instr[14:12] <= 3'b001);
            OP_B:    legal = (instr[14:12] <= 3'b011);
            default: legal = 1'b0;
        endcase
    end

    logic [31:0] branch_tgt;
    assign branch_tgt = pc + imm;

    assign imem_req  = (state == S_FETCH);
    assign imem_addr = pc;
    assign busy      = (state == S_FETCH) || (state == S_DECODE) ||
                       (state == S_EXEC)  || (state == S_WB);
    assign alu_en    = (state == S_EXEC) && (exec_cnt == 4'd0);
    assign rf_we     = (state == S_WB) && (rd_addr != 5'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            instr       <= 32'h0;
            imm         <= 32'h0;
            retired     <= 32'h0;
            alu_sel     <= 2'b00;
            alu_control <= 3'b000;
            rs1_addr    <= 5'd0;
            rs2_addr    <= 5'd0;
            rd_addr     <= 5'd0;
            fault       <= 2'b00;
            fetch_cnt   <= 8'd0;
            exec_cnt    <= 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    fetch_cnt <= 8'd0;
                    if (start) state <= S_FETCH;
                end
                S_FETCH: begin
                    // Ack is checked first so an ack on the timeout cycle wins.
                    if (imem_ack) begin
                        instr       <= imem_rdata;
                        alu_sel     <= d_sel;
                        alu_control <= imem_rdata[14:12];
                        rs1_addr    <= imem_rdata[19:15];
                        rs2_addr    <= imem_rdata[24:20];
                        rd_addr     <= d_rd;
                        imm         <= d_imm;
                        state       <= S_DECODE;
                    end else if (fetch_cnt == FETCH_LAST) begin
                        fault <= 2'b10;
                        state <= S_HALT;
                    end else begin
                        fetch_cnt <= fetch_cnt + 8'd1;
                    end
                end
                S_DECODE: begin
                    exec_cnt <= 4'd0;
                    if (legal) begin
                        state <= S_EXEC;
                    end else begin
                        fault <= 2'b01;
                        state <= S_HALT;
                    end
                end
                S_EXEC: begin
                    if (exec_cnt != EXEC_LAST) begin
                        exec_cnt <= exec_cnt + 4'd1;
                    end else if (alu_sel == 2'b10) begin
                        if (bt && (branch_tgt[1:0] != 2'b00)) begin
                            fault <= 2'b11;
                            state <= S_HALT;
                        end else begin
                            pc        <= bt ? branch_tgt : pc + 32'd4;
                            retired   <= retired + 32'd1;
                            fetch_cnt <= 8'd0;
                            state     <= stop ? S_IDLE : S_FETCH;
                        end
                    end else begin
                        state <= S_WB;
                    end
                end
                S_WB: begin
                    pc        <= pc + 32'd4;
                    retired   <= retired + 32'd1;
                    fetch_cnt <= 8'd0;
                    state     <= stop ? S_IDLE : S_FETCH;
                end
                S_HALT: state <= S_HALT;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_seq_ctrl.sv
// tb/tb_riscv_seq_ctrl.sv - self-checking bench for riscv_seq_ctrl
module tb_riscv_seq_ctrl;

    localparam int EXEC_CYCLES = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [1:0]  alu_sel;
    logic [2:0]  alu_control;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic [31:0] imm;
    logic        alu_en;
    logic        bt = 1'b0;
    logic        rf_we;
    logic [31:0] pc;
    logic        busy;
    logic [1:0]  fault;
    logic [31:0] retired;

    riscv_seq_ctrl #(
        .RESET_PC(32'h0), .EXEC_CYCLES(EXEC_CYCLES), .FETCH_TIMEOUT(15)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .alu_sel(alu_sel), .alu_control(alu_control),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr), .imm(imm),
        .alu_en(alu_en), .bt(bt), .rf_we(rf_we), .pc(pc), .busy(busy),
        .fault(fault), .retired(retired)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        known;
        logic        legal;
        logic        is_b;
        logic [1:0]  sel;
        logic [2:0]  f3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
    } dec_t;

    // Expected state of the model
    logic        e_req, e_busy, e_alu, e_we;
    logic [31:0] e_pc, e_ret;
    logic [1:0]  e_fault;
    dec_t        e_dec;
    logic        en = 1'b0;
    logic        dec_en = 1'b0;

    function automatic dec_t model_decode(input logic [31:0] ins);
        dec_t d;
        logic [12:0] bimm;
        d = '0;
        d.f3  = ins[14:12];
        d.rs1 = ins[19:15];
        d.rs2 = ins[24:20];
        d.rd  = ins[11:7];
        case (ins[6:0])
            7'h33: begin d.known = 1; d.sel = 2'd0; d.legal = (ins[14:12] <= 4); end
            7'h13: begin
                d.known = 1; d.sel = 2'd1; d.legal = (ins[14:12] <= 1);
                d.imm = 32'($signed(ins[31:20]));
            end
            7'h63: begin
                d.known = 1; d.sel = 2'd2; d.legal = (ins[14:12] <= 3);
                d.is_b = 1; d.rd = 5'd0;
                bimm = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
                d.imm = 32'($signed(bimm));
            end
            default: d.known = 0;
        endcase
        return d;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (en) begin
            chk("busy", 32'(busy), 32'(e_busy));
            chk("imem_req", 32'(imem_req), 32'(e_req));
            chk("alu_en", 32'(alu_en), 32'(e_alu));
            chk("rf_we", 32'(rf_we), 32'(e_we));
            chk("pc", pc, e_pc);
            chk("imem_addr", imem_addr, e_pc);
            chk("retired", retired, e_ret);
            chk("fault", 32'(fault), 32'(e_fault));
            if (dec_en) begin
                chk("alu_sel", 32'(alu_sel), 32'(e_dec.sel));
                chk("alu_control", 32'(alu_control), 32'(e_dec.f3));
                chk("rs1", 32'(rs1_addr), 32'(e_dec.rs1));
                chk("rs2", 32'(rs2_addr), 32'(e_dec.rs2));
                chk("rd", 32'(rd_addr), 32'(e_dec.rd));
                chk("imm", imm, e_dec.imm);
            end
        end
    end

    // One clock cycle with the given strobe expectations.
    task automatic step(input logic rq, input logic bz, input logic ae, input logic we);
        e_req = rq; e_busy = bz; e_alu = ae; e_we = we;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        en = 0;
        reset = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 0;
        e_pc = 0; e_ret = 0; e_fault = 0; e_dec = '0; dec_en = 1;
        en = 1;
    endtask

    task automatic halt_cycles();
        imem_ack = 1; start = 1;
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        imem_ack = 0; start = 0;
    endtask

    task automatic run(input logic [31:0] ins, input int dly, input logic b_taken,
                       input logic stp, input logic from_idle);
        dec_t d;
        logic [31:0] tgt;
        d = model_decode(ins);
        stop = stp;
        if (from_idle) begin
            start = 1; step(0, 0, 0, 0); start = 0;
        end
        for (int k = 0; k <= dly; k++) begin
            imem_ack = (k == dly);
            imem_rdata = (k == dly) ? ins : ~ins;
            step(1, 1, 0, 0);
        end
        imem_ack = 0; imem_rdata = 32'hdead_beef;
        e_dec = d; dec_en = d.known;
        step(0, 1, 0, 0);
        if (!d.legal) begin
            e_fault = 2'b01;
            halt_cycles();
            return;
        end
        bt = b_taken;
        for (int e = 0; e < EXEC_CYCLES; e++) step(0, 1, e == 0, 0);
        bt = 0;
        if (d.is_b) begin
            if (b_taken) begin
                tgt = e_pc + d.imm;
                if (tgt[1:0] != 2'b00) begin
                    e_fault = 2'b11;
                    halt_cycles();
                    return;
                end
                e_pc = tgt;
            end else begin
                e_pc = e_pc + 4;
            end
            e_ret = e_ret + 1;
        end else begin
            step(0, 1, 0, d.rd != 0);
            e_pc = e_pc + 4;
            e_ret = e_ret + 1;
        end
    endtask

    initial begin
        e_req = 0; e_busy = 0; e_alu = 0; e_we = 0;
        do_reset();
        chk("reset_pc", pc, 32'h0);
        chk("reset_retired", retired, 32'h0);
        chk("reset_fault", 32'(fault), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        step(0, 0, 0, 0);

        run(32'h00A08513, 0, 0, 1, 1);
        chk("addi_imm_lit", imm, 32'd10);
        chk("addi_rd_lit", 32'(rd_addr), 32'd10);
        chk("addi_pc_lit", pc, 32'd4);
        chk("addi_ret_lit", retired, 32'd1);
        step(0, 0, 0, 0);
        run(32'h00310533, 2, 0, 0, 1);
        run(32'h00A08513, 1, 0, 1, 0);
        step(0, 0, 0, 0);
        run(32'h00A08013, 0, 0, 1, 1);
        chk("chain_pc_lit", pc, 32'd16);
        run(32'h00208463, 0, 1, 1, 1);
        chk("beq_imm_lit", imm, 32'd8);
        chk("beq_taken_pc_lit", pc, 32'd24);
        run(32'h00208463, 0, 0, 1, 1);
        chk("beq_nt_pc_lit", pc, 32'd28);
        run(32'hFE209EE3, 0, 1, 1, 1);
        chk("bne_imm_lit", imm, 32'hFFFF_FFFC);
        chk("bne_pc_lit", pc, 32'd24);
        run(32'h00208363, 0, 1, 1, 1);
        chk("misalign_fault_lit", 32'(fault), 32'd3);
        chk("misalign_pc_lit", pc, 32'd24);

        do_reset();
        run(32'h00005033, 0, 0, 1, 1);
        chk("illegal_fault_lit", 32'(fault), 32'd1);
        chk("illegal_ret_lit", retired, 32'd0);
        do_reset();
        run(32'h0000007F, 0, 0, 1, 1);
        do_reset();
        run(32'h00002013, 0, 0, 1, 1);
        do_reset();

        start = 1; step(0, 0, 0, 0); start = 0;
        for (int k = 0; k < 15; k++) step(1, 1, 0, 0);
        e_fault = 2'b10;
        halt_cycles();
        chk("timeout_fault_lit", 32'(fault), 32'd2);
        do_reset();
        run(32'h00A08513, 14, 0, 1, 1);
        chk("late_ack_pc_lit", pc, 32'd4);

        start = 1; step(0, 0, 0, 0); start = 0;
        imem_ack = 1; imem_rdata = 32'h00310533; step(1, 1, 0, 0); imem_ack = 0;
        e_dec = model_decode(32'h00310533);
        step(0, 1, 0, 0);
        reset = 1;
        step(0, 1, 1, 0);
        reset = 0;
        e_pc = 0; e_ret = 0; e_dec = '0;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("exec_reset_busy_lit", 32'(busy), 32'd0);

        en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
